// File: rtl/ssb_seq_pkg.sv
// ssb_seq_pkg: shared constants for the ssb_out drive sequencer.
// FSM state codes, unity gain for the default gw, flush length.
package ssb_seq_pkg;

  localparam int GW_DEF = 16;

  localparam logic [GW_DEF:0] GAIN_ONE =
    {1'b1, {GW_DEF{1'b0}}};

  localparam int FLUSH_FRAMES = 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;

endpackage

// File: rtl/env_ramp.sv
// env_ramp: saturating envelope gain accumulator, clamped to
// 0..2^gw. Ports: clk, reset; up/down/load/clear strobes (one
// update per asserted cycle, priority clear>load>up>down); step
// increment; gain register; full_nxt/zero_nxt flag that the next
// up/down result would land on the clamp.
module env_ramp
  import ssb_seq_pkg::*;
#(
  parameter int gw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up,
  input  logic          down,
  input  logic          load,
  input  logic          clear,
  input  logic [gw-1:0] step,
  output logic [gw:0]   gain,
  output logic          full_nxt,
  output logic          zero_nxt
);

  localparam logic [gw:0] ONE = {1'b1, {gw{1'b0}}};

  logic [gw+1:0] sum;
  logic [gw:0]   up_v;
  logic [gw:0]   dn_v;
  logic [gw:0]   nxt;

  always_comb begin
    sum  = {1'b0, gain} + {2'b00, step};
    up_v = (sum >= {1'b0, ONE}) ? ONE : sum[gw:0];
    dn_v = (gain > {1'b0, step}) ?
           gain - {1'b0, step} : '0;
    full_nxt = (up_v == ONE);
    zero_nxt = (dn_v == '0);
    nxt = gain;
    if (clear)     nxt = '0;
    else if (load) nxt = ONE;
    else if (up)   nxt = up_v;
    else if (down) nxt = dn_v;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gain <= '0;
    else       gain <= nxt;
  end

endmodule

// File: rtl/ssb_drive_seq.sv
// ssb_drive_seq: pulse/envelope sequencer feeding ssb_out.
// Ports: clk, reset (async high); start/stop requests; amp_i/amp_q
// setpoints; ramp_step, pulse_len; outputs div_state frame phase,
// interleaved drive, enable, gain, busy, done.
// Build option SSB_DRIVE_SEQ_SOFT_STOP_EN: stop ramps gain down
// from its current value instead of cutting straight to FLUSH.
module ssb_drive_seq
  import ssb_seq_pkg::*;
#(
  parameter int dw = 18,
  parameter int gw = 16,
  parameter int lw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [dw-1:0] amp_i,
  input  logic [dw-1:0] amp_q,
  input  logic [gw-1:0] ramp_step,
  input  logic [lw-1:0] pulse_len,
  output logic [1:0]    div_state,
  output logic [dw-1:0] drive,
  output logic          enable,
  output logic [gw:0]   gain,
  output logic          busy,
  output logic          done
);

  localparam int PW = dw + gw + 1;
  localparam logic [1:0] FL_LAST = 2'(FLUSH_FRAMES - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          start_p;
  logic          stop_p;
  logic          stop_ok;
  logic [dw-1:0] amp_i_l;
  logic [dw-1:0] amp_q_l;
  logic [lw-1:0] hcnt;
  logic [1:0]    fcnt;
  logic          tick;
  logic          up;
  logic          dn;
  logic          ld;
  logic          clr;
  logic          fin;
  logic          stopping;
  logic          begin_down;
  logic          full_nxt;
  logic          zero_nxt;
  logic          up_full;
  logic          dn_zero;

  logic signed [PW-1:0] prod_i;
  logic signed [PW-1:0] prod_q;
  logic [dw-1:0]        i_term;
  logic [dw-1:0]        q_term;

  assign tick    = (div_state == 2'd3);
  assign enable  = (state != S_IDLE);
  assign busy    = enable | start_p;
  assign stop_ok = stop & ((state == S_RAMP_UP) |
                           (state == S_HOLD) |
                           (state == S_RAMP_DOWN));

  // Zero step means "jump": straight to full or to zero.
  assign up_full = (ramp_step == '0) | full_nxt;
  assign dn_zero = (ramp_step == '0) | zero_nxt;

  env_ramp #(.gw(gw)) u_env (
    .clk      (clk),
    .reset    (reset),
    .up       (up),
    .down     (dn),
    .load     (ld),
    .clear    (clr),
    .step     (ramp_step),
    .gain     (gain),
    .full_nxt (full_nxt),
    .zero_nxt (zero_nxt)
  );

  // Each boundary tick applies one gain step, so the ramp
  // gains are symmetric: 0 | s, 2s .. | ONE .. | .. 2s, s | 0.
  always_comb begin
    state_nxt  = state;
    up         = 1'b0;
    dn         = 1'b0;
    ld         = 1'b0;
    clr        = 1'b0;
    fin        = 1'b0;
    stopping   = 1'b0;
    begin_down = 1'b0;
    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (start_p) begin
            if (up_full) begin
              ld = 1'b1;
              state_nxt = S_HOLD;
            end else begin
              up = 1'b1;
              state_nxt = S_RAMP_UP;
            end
          end
        end
        S_RAMP_UP: begin
          if (stop_p) stopping = 1'b1;
          else if (up_full) begin
            ld = 1'b1;
            state_nxt = S_HOLD;
          end else up = 1'b1;
        end
        S_HOLD: begin
          if (stop_p) stopping = 1'b1;
          else if (pulse_len != '0 &&
                   hcnt == pulse_len - lw'(1))
            begin_down = 1'b1;
        end
        S_RAMP_DOWN: begin
          if (stop_p) stopping = 1'b1;
          else begin_down = 1'b1;
        end
        S_FLUSH: begin
          if (fcnt == FL_LAST) fin = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
`ifdef SSB_DRIVE_SEQ_SOFT_STOP_EN
      if (stopping) begin_down = 1'b1;
`else
      if (stopping) begin
        clr = 1'b1;
        state_nxt = S_FLUSH;
      end
`endif
      if (begin_down) begin
        if (dn_zero) begin
          clr = 1'b1;
          state_nxt = S_FLUSH;
        end else begin
          dn = 1'b1;
          state_nxt = S_RAMP_DOWN;
        end
      end
      if (fin) state_nxt = S_IDLE;
    end
  end

  // Full-width product; >>> then truncation floors toward -inf.
  always_comb begin
    prod_i = PW'($signed(amp_i_l)) * PW'($signed({1'b0, gain}));
    prod_q = PW'($signed(amp_q_l)) * PW'($signed({1'b0, gain}));
    i_term = dw'(prod_i >>> gw);
    q_term = dw'(prod_q >>> gw);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_state <= 2'd0;
      state     <= S_IDLE;
      start_p   <= 1'b0;
      stop_p    <= 1'b0;
      amp_i_l   <= '0;
      amp_q_l   <= '0;
      hcnt      <= '0;
      fcnt      <= '0;
      drive     <= '0;
      done      <= 1'b0;
    end else begin
      div_state <= div_state + 2'd1;
      state     <= state_nxt;
      done      <= fin;
      drive     <= div_state[0] ? q_term : i_term;
      if (start && !stop && !busy) begin
        start_p <= 1'b1;
        amp_i_l <= amp_i;
        amp_q_l <= amp_q;
      end else if (tick && state == S_IDLE) begin
        start_p <= 1'b0;
      end
      // A stop seen on the tick itself waits for the next tick.
      stop_p <= tick ? stop_ok : (stop_p | stop_ok);
      if (state != S_HOLD) hcnt <= '0;
      else if (tick)       hcnt <= hcnt + lw'(1);
      if (state != S_FLUSH) fcnt <= '0;
      else if (tick)        fcnt <= fcnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_ssb_drive_seq.sv
// tb_ssb_drive_seq: directed self-checking bench for ssb_drive_seq.
// Drives on negedge, samples on negedge; one task per scenario.
module tb_ssb_drive_seq;

  logic               clk;
  logic               reset;
  logic               start;
  logic               stop;
  logic signed [17:0] amp_i;
  logic signed [17:0] amp_q;
  logic [15:0]        ramp_step;
  logic [15:0]        pulse_len;
  logic [1:0]         div_state;
  logic signed [17:0] drive;
  logic               enable;
  logic [16:0]        gain;
  logic               busy;
  logic               done;

  int n_chk  = 0;
  int n_pass = 0;

  ssb_drive_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .amp_i     (amp_i),
    .amp_q     (amp_q),
    .ramp_step (ramp_step),
    .pulse_len (pulse_len),
    .div_state (div_state),
    .drive     (drive),
    .enable    (enable),
    .gain      (gain),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_ds(input logic [1:0] v);
    int n = 0;
    @(negedge clk);
    while (div_state !== v && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (div_state !== v) begin
      n_chk++;
      $display("FAIL wait_ds: div_state %0d never %0d",
               div_state, v);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    if (busy) begin
      n_chk++;
      $display("FAIL wait_idle: busy stuck at %0b", busy);
    end
  endtask

  task automatic go(input int ai, input int aq,
                    input int st, input int len);
    amp_i     = 18'(ai);
    amp_q     = 18'(aq);
    ramp_step = 16'(st);
    pulse_len = 16'(len);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    amp_i = '0;
    amp_q = '0;
    ramp_step = '0;
    pulse_len = '0;
    cyc();
    cyc();
    n_chk++;
    if (div_state !== 2'd0 || drive !== 18'sd0)
      $display("FAIL rst_ds_drive: ds=%0d drv=%0d want 0/0",
               div_state, drive);
    else n_pass++;
    n_chk++;
    if (enable !== 1'b0 || gain !== 17'd0)
      $display("FAIL rst_en_gain: en=%0b gain=%0d want 0/0",
               enable, gain);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_busy_done: busy=%0b done=%0b want 0/0",
               busy, done);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_ramp_hold();
    int exp_i[18] = '{30000, 60000, 90000,
                      120000, 120000, 120000, 120000, 120000,
                      120000, 120000, 120000, 120000, 120000,
                      90000, 60000, 30000, 0, 0};
    wait_ds(2'd1);
    go(120000, 0, 16384, 10);
    for (int f = 0; f < 18; f++) begin
      wait_ds(2'd1);
      n_chk++;
      if (drive !== 18'(exp_i[f]) || enable !== 1'b1 ||
          done !== 1'b0)
        $display("FAIL ramp_i f%0d: drv=%0d en=%0b dn=%0b want %0d/1/0",
                 f, drive, enable, done, exp_i[f]);
      else n_pass++;
    end
    wait_ds(2'd0);
    n_chk++;
    if (done !== 1'b1 || enable !== 1'b0 || busy !== 1'b0)
      $display("FAIL ramp_done: dn=%0b en=%0b busy=%0b want 1/0/0",
               done, enable, busy);
    else n_pass++;
    cyc();
    n_chk++;
    if (done !== 1'b0)
      $display("FAIL ramp_done_once: done=%0b want 0", done);
    else n_pass++;
  endtask

  task automatic test_instant();
    int exp_i[5] = '{20000, 20000, 20000, 0, 0};
    int exp_g[5] = '{65536, 65536, 65536, 0, 0};
    wait_ds(2'd1);
    go(20000, 0, 0, 3);
    for (int f = 0; f < 5; f++) begin
      wait_ds(2'd1);
      n_chk++;
      if (drive !== 18'(exp_i[f]) || gain !== 17'(exp_g[f]))
        $display("FAIL inst_i f%0d: drv=%0d gain=%0d want %0d/%0d",
                 f, drive, gain, exp_i[f], exp_g[f]);
      else n_pass++;
      cyc();
      n_chk++;
      if (drive !== 18'sd0)
        $display("FAIL inst_q f%0d: drv=%0d want 0", f, drive);
      else n_pass++;
    end
    wait_ds(2'd0);
    n_chk++;
    if (done !== 1'b1 || enable !== 1'b0)
      $display("FAIL inst_done: dn=%0b en=%0b want 1/0",
               done, enable);
    else n_pass++;
  endtask

  task automatic test_negative();
    int e;
    wait_ds(2'd1);
    go(-131072, 131071, 0, 0);
    wait_ds(2'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      e = (k % 2 == 1) ? 131071 : -131072;
      n_chk++;
      if (drive !== 18'(e))
        $display("FAIL neg_ext k%0d: drv=%0d want %0d",
                 k, drive, e);
      else n_pass++;
    end
    pulse_stop();
    wait_idle();
    wait_ds(2'd1);
    go(-120000, -3, 16384, 0);
    wait_ds(2'd1);
    n_chk++;
    if (drive !== -18'sd30000 || gain !== 17'd16384)
      $display("FAIL neg_quarter: drv=%0d gain=%0d want -30000/16384",
               drive, gain);
    else n_pass++;
    cyc();
    n_chk++;
    if (drive !== -18'sd1)
      $display("FAIL neg_floor: drv=%0d want -1", drive);
    else n_pass++;
    pulse_stop();
    wait_idle();
  endtask

  task automatic test_stop_cw();
`ifdef SSB_DRIVE_SEQ_SOFT_STOP_EN
    int exp_g[5] = '{49152, 32768, 16384, 0, 0};
`else
    int exp_g[2] = '{0, 0};
`endif
    wait_ds(2'd1);
    go(40000, 0, 16384, 0);
    for (int f = 0; f < 5; f++) wait_ds(2'd1);
    n_chk++;
    if (gain !== 17'd65536 || drive !== 18'sd40000)
      $display("FAIL cw_hold: gain=%0d drv=%0d want 65536/40000",
               gain, drive);
    else n_pass++;
    pulse_stop();
    for (int f = 0; f < $size(exp_g); f++) begin
      wait_ds(2'd1);
      n_chk++;
      if (gain !== 17'(exp_g[f]) || enable !== 1'b1)
        $display("FAIL cw_stop f%0d: gain=%0d en=%0b want %0d/1",
                 f, gain, enable, exp_g[f]);
      else n_pass++;
    end
    wait_ds(2'd0);
    n_chk++;
    if (done !== 1'b1 || enable !== 1'b0)
      $display("FAIL cw_done: dn=%0b en=%0b want 1/0",
               done, enable);
    else n_pass++;
  endtask

  task automatic test_collide();
    wait_ds(2'd1);
    go(1000, 0, 0, 0);
    wait_ds(2'd1);
    amp_i = 18'sd5000;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_ds(2'd1);
    n_chk++;
    if (drive !== 18'sd1000)
      $display("FAIL busy_start: drv=%0d want 1000", drive);
    else n_pass++;
    pulse_stop();
    wait_idle();

    wait_ds(2'd1);
    amp_i = 18'sd7777;
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    n_chk++;
    if (busy !== 1'b0)
      $display("FAIL ss_busy: busy=%0b want 0", busy);
    else n_pass++;
    wait_ds(2'd0);
    n_chk++;
    if (enable !== 1'b0 || busy !== 1'b0)
      $display("FAIL ss_idle: en=%0b busy=%0b want 0/0",
               enable, busy);
    else n_pass++;

    wait_ds(2'd1);
    go(8000, 0, 16384, 2);
    cyc();
    n_chk++;
    if (busy !== 1'b1 || enable !== 1'b0)
      $display("FAIL mid_pend: busy=%0b en=%0b want 1/0",
               busy, enable);
    else n_pass++;
    cyc();
    n_chk++;
    if (enable !== 1'b1 || gain !== 17'd16384)
      $display("FAIL mid_entry: en=%0b gain=%0d want 1/16384",
               enable, gain);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    wait_ds(2'd1);
    go(50000, 0, 4096, 0);
    wait_ds(2'd1);
    wait_ds(2'd1);
    n_chk++;
    if (gain !== 17'd8192 || drive !== 18'sd6250)
      $display("FAIL rmid_pre: gain=%0d drv=%0d want 8192/6250",
               gain, drive);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (drive !== 18'sd0 || enable !== 1'b0 ||
        gain !== 17'd0 || div_state !== 2'd0 || busy !== 1'b0)
      $display("FAIL rmid_async: drv=%0d en=%0b g=%0d ds=%0d bz=%0b want 0s",
               drive, enable, gain, div_state, busy);
    else n_pass++;
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (done === 1'b1 || enable === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0)
      $display("FAIL rmid_quiet: %0d cycles with done/en, want 0",
               seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp_hold();
    test_instant();
    test_negative();
    test_stop_cw();
    test_collide();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
